adc_trigger_capture: RTL and testbench

//  Triggered snapshot stage between one ADC AXI4-Stream (8x16-bit samples/beat) and its readout buffer stream.

---
 rtl/adc_capture_pkg.sv | 19 +
 rtl/adc_capture_ram.sv | 28 ++
 rtl/adc_trigger_capture.sv | 187 ++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC trigger/capture slice.
package adc_capture_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ARMED,
      POST,
      READOUT
   } cap_state_t;

   localparam int ADC_BEAT_WIDTH = 128;

   // Pointer width for a DEPTH-entry circular buffer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port history RAM: one write port, registered read, no reset on contents.
module adc_capture_ram #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 512,
   parameter int AW         = 9
) (
   input  logic                  aclk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: one beat per cycle while recording.
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read port: 1-cycle latency, holds last value when idle.
   always_ff @(posedge aclk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/adc_trigger_capture.sv
// Triggered snapshot of an ADC stream into a circular history, drained oldest-first.
module adc_trigger_capture
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH = ADC_BEAT_WIDTH,
   parameter int DEPTH      = 512,
   parameter int POST_LEN   = 384
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   input  logic                  arm_i,
   input  logic                  trig_i,
   output logic                  armed_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int AW = ptr_width(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] PRE_TC    = CW'(DEPTH - POST_LEN);
   localparam logic [CW-1:0] PRE_LAST  = CW'(DEPTH - POST_LEN - 1);
   localparam logic [CW-1:0] POST_TC   = CW'(POST_LEN);
   localparam logic [CW-1:0] POST_LAST = CW'(POST_LEN - 1);
   localparam logic [CW-1:0] FRAME_LEN = CW'(DEPTH);

   cap_state_t            state;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         fill_cnt;
   logic [CW-1:0]         post_cnt;
   logic [CW-1:0]         rd_left;
   logic                  acc;
   logic                  wr_en;
   logic                  rd_en;
   logic                  pop;
   logic                  rd_pend;
   logic                  rd_pend_last;
   logic [1:0]            occ_next;
   logic [1:0]            sk_cnt;
   logic                  sk_widx;
   logic [1:0][DATA_WIDTH-1:0] sk_data;
   logic [1:0]            sk_last;
   logic [DATA_WIDTH-1:0] ram_q;

   assign acc   = s_axis_tvalid & s_axis_tready;
   assign wr_en = acc & ((state == FILL) | (state == ARMED) | (state == POST));
   assign pop   = m_axis_tvalid & m_axis_tready;

   // Issue a RAM read only when the skid has room for it once in-flight data lands.
   always_comb begin
      occ_next = sk_cnt + {1'b0, rd_pend} - {1'b0, pop};
      rd_en    = (state == READOUT) && (rd_left != '0) && (occ_next < 2'd2);
   end

   adc_capture_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_ram (
      .aclk   (aclk),
      .wr_en  (wr_en),
      .wr_addr(wr_ptr),
      .wr_data(s_axis_tdata),
      .rd_en  (rd_en),
      .rd_addr(rd_ptr),
      .rd_data(ram_q)
   );

   // Capture FSM with pointers, counters and registered status outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fill_cnt      <= '0;
         post_cnt      <= '0;
         rd_left       <= '0;
         s_axis_tready <= 1'b0;
         armed_o       <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         s_axis_tready <= 1'b1;
         done_o        <= 1'b0;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         case (state)
            IDLE: begin
               // arm beats a simultaneous trigger: trig_i is not looked at here
               if (arm_i) begin
                  state    <= FILL;
                  fill_cnt <= '0;
                  busy_o   <= 1'b1;
               end
            end
            FILL: begin
               if (acc) begin
                  if (fill_cnt != PRE_TC) fill_cnt <= fill_cnt + CW'(1);
                  if (fill_cnt == PRE_LAST) begin
                     state   <= ARMED;
                     armed_o <= 1'b1;
                  end
               end
            end
            ARMED: begin
               if (trig_i) begin
                  armed_o  <= 1'b0;
                  post_cnt <= acc ? CW'(1) : '0;
                  if (acc && (POST_LEN == 1)) begin
                     state   <= READOUT;
                     rd_ptr  <= wr_ptr + AW'(1);
                     rd_left <= FRAME_LEN;
                  end else begin
                     state <= POST;
                  end
               end
            end
            POST: begin
               if (acc) begin
                  if (post_cnt != POST_TC) post_cnt <= post_cnt + CW'(1);
                  if (post_cnt == POST_LAST) begin
                     // slot after the last written beat holds the oldest frame beat
                     state   <= READOUT;
                     rd_ptr  <= wr_ptr + AW'(1);
                     rd_left <= FRAME_LEN;
                  end
               end
            end
            READOUT: begin
               if (rd_en) begin
                  rd_ptr  <= rd_ptr + AW'(1);
                  rd_left <= rd_left - CW'(1);
               end
               if (pop && m_axis_tlast) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               armed_o <= 1'b0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

   // Skid occupancy and read-in-flight tracking; reset empties the pipe immediately.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sk_cnt       <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
      end else begin
         rd_pend      <= rd_en;
         rd_pend_last <= rd_en && (rd_left == CW'(1));
         sk_cnt       <= sk_cnt + {1'b0, rd_pend} - {1'b0, pop};
      end
   end

   // Landing slot for RAM data: behind the head unless the skid drains to empty.
   assign sk_widx = (sk_cnt - {1'b0, pop}) != 2'd0;

   // Skid payload: shift on pop, land RAM data in the next free slot.
   always_ff @(posedge aclk) begin
      if (pop) begin
         sk_data[0] <= sk_data[1];
         sk_last[0] <= sk_last[1];
      end
      if (rd_pend) begin
         sk_data[sk_widx] <= ram_q;
         sk_last[sk_widx] <= rd_pend_last;
      end
   end

   assign m_axis_tvalid = (sk_cnt != 2'd0);
   assign m_axis_tdata  = sk_data[0];
   assign m_axis_tlast  = m_axis_tvalid & sk_last[0];

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Scoreboard bench for adc_trigger_capture at DEPTH=16, POST_LEN=8.
module tb_adc_trigger_capture;

   localparam int DW = 128;

   typedef struct {
      logic [DW-1:0] data;
      int            idx;
      bit            last;
   } exp_t;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          arm_i;
   logic          trig_i;
   logic          armed_o;
   logic          busy_o;
   logic          done_o;

   int   n_chk = 0;
   int   n_pass = 0;
   int   n = 0;
   int   cyc = 0;
   int   pop_cnt = 0;
   int   done_cnt = 0;
   int   rise_cyc = 0;
   int   first_pop_cyc = 0;
   int   last_pop_cyc = 0;
   int   c_ro = 0;
   bit   rdy_mode = 1'b0;
   exp_t exp_q[$];

   adc_trigger_capture #(
      .DATA_WIDTH(DW),
      .DEPTH     (16),
      .POST_LEN  (8)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .arm_i        (arm_i),
      .trig_i       (trig_i),
      .armed_o      (armed_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Sink readiness: always 1, or the repeating 1,0,0 pattern.
   initial begin
      int rc;
      rc = 0;
      m_axis_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         rc++;
         m_axis_tready = rdy_mode ? (rc % 3 == 0) : 1'b1;
      end
   end

   // Output monitor: scoreboard compare, stall stability, done timing.
   bit            prev_last_pop = 1'b0;
   bit            prev_stall = 1'b0;
   bit            prev_vld = 1'b0;
   logic [DW-1:0] prev_data;
   bit            prev_tlast;
   exp_t          e;
   always @(negedge aclk) begin
      if (!aresetn) begin
         prev_last_pop = 1'b0;
         prev_stall    = 1'b0;
         prev_vld      = 1'b0;
      end else begin
         if (done_o || prev_last_pop) chk("done_o", done_o, prev_last_pop);
         if (done_o) done_cnt++;
         if (prev_stall) begin
            chk("stall_vld", m_axis_tvalid, 1);
            chk("stall_data", m_axis_tdata, prev_data);
            chk("stall_last", m_axis_tlast, prev_tlast);
         end
         if (m_axis_tvalid && !prev_vld) rise_cyc = cyc;
         prev_last_pop = 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("beat_data", m_axis_tdata, e.data);
               chk("beat_last", m_axis_tlast, e.last);
               if (e.idx == 0) first_pop_cyc = cyc;
               if (e.last) last_pop_cyc = cyc;
            end
            pop_cnt++;
            prev_last_pop = m_axis_tlast;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_tlast = m_axis_tlast;
         prev_vld   = m_axis_tvalid;
      end
   end

   // One input cycle; data is the accepted-beat counter.
   task automatic tick(input bit v, input bit arm, input bit trig);
      s_axis_tvalid      = v;
      s_axis_tdata       = '0;
      s_axis_tdata[31:0] = n;
      arm_i              = arm;
      trig_i             = trig;
      @(posedge aclk);
      #1;
      if (v) n++;
      arm_i  = 1'b0;
      trig_i = 1'b0;
   endtask

   // Arm, optional early trigger, trigger at trig_n, then POST_LEN post beats.
   task automatic start_frame(input int trig_n, input int early_trig, input bit gaps,
                              input bit noise, input bit arm_trig, input int first);
      exp_t x;
      int   post;
      int   k;
      bit   v;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         x.data       = '0;
         x.data[31:0] = first + i;
         x.idx        = i;
         x.last       = (i == 15);
         exp_q.push_back(x);
      end
      tick(1, 1, arm_trig);
      chk("busy_after_arm", busy_o, 1);
      while (n < trig_n) begin
         tick(1, 0, n == early_trig);
         if (n == 5) chk("armed_in_fill", armed_o, 0);
      end
      chk("armed_pre_trig", armed_o, 1);
      tick(1, 0, 1);
      chk("armed_post_trig", armed_o, 0);
      post = 1;
      k    = 0;
      while (post < 8) begin
         k++;
         v = !(gaps && (k % 3 == 0));
         tick(v, noise && (post == 3), 0);
         if (v) post++;
      end
      c_ro = cyc;
   endtask

   // Wait for done_o with a bound, then check the frame closed cleanly.
   task automatic finish_frame(input int base_done, input bit noise, input bit measure);
      int t;
      t = 0;
      while (done_cnt == base_done && t < 200) begin
         tick(1, noise && (t == 3 || t == 6), noise && (t == 4));
         t++;
      end
      chk("done_seen", done_cnt != base_done, 1);
      tick(0, 0, 0);
      tick(0, 0, 0);
      chk("busy_after_done", busy_o, 0);
      chk("one_done", done_cnt - base_done, 1);
      chk("queue_empty", exp_q.size(), 0);
      if (measure) begin
         chk("first_vld_latency", (rise_cyc - c_ro) <= 2, 1);
         chk("drain_span", last_pop_cyc - first_pop_cyc, 15);
      end
   endtask

   task automatic run_frame(input int trig_n, input int early_trig, input bit gaps, input bit noise,
                            input bit arm_trig, input int first, input bit measure);
      int base_done;
      base_done = done_cnt;
      start_frame(trig_n, early_trig, gaps, noise, arm_trig, first);
      finish_frame(base_done, noise, measure);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int base_done;
      int base_pop;
      int t;
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      arm_i         = 1'b0;
      trig_i        = 1'b0;
      #3;
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_armed", armed_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      #19;
      aresetn = 1'b1;
      #1;
      chk("tready_before_clk", s_axis_tready, 0);
      @(posedge aclk);
      #1;
      chk("tready_after_clk", s_axis_tready, 1);
      tick(0, 0, 0);

      // 1: basic frame, full-rate drain
      run_frame(20, -1, 0, 0, 0, 12, 1);
      // 2: arm+trig together, trigger in FILL ignored, trigger at 10
      run_frame(10, 3, 0, 0, 1, 2, 0);
      // 3: backpressure 1,0,0
      rdy_mode = 1'b1;
      run_frame(20, -1, 0, 0, 0, 12, 0);
      rdy_mode = 1'b0;
      tick(0, 0, 0);
      tick(0, 0, 0);
      // 4: input gaps during POST
      run_frame(20, -1, 1, 0, 0, 12, 0);

      // 5: reset while draining, then a clean frame
      base_done = done_cnt;
      base_pop  = pop_cnt;
      start_frame(20, -1, 0, 0, 0, 12);
      t = 0;
      while ((pop_cnt - base_pop) < 4 && t < 100) begin
         tick(1, 0, 0);
         t++;
      end
      chk("abort_reached_beat5", (pop_cnt - base_pop) >= 4, 1);
      #2;
      aresetn = 1'b0;
      #1;
      chk("abort_tvalid", m_axis_tvalid, 0);
      chk("abort_busy", busy_o, 0);
      exp_q.delete();
      #10;
      aresetn = 1'b1;
      for (int i = 0; i < 4; i++) tick(0, 0, 0);
      chk("abort_no_done", done_cnt, base_done);
      chk("abort_idle", busy_o, 0);
      run_frame(20, -1, 0, 0, 0, 12, 1);

      // 6: arm/trig noise during POST and READOUT
      run_frame(20, -1, 0, 1, 0, 12, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
